// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed seven-segment driver.
// Segment bit order is {a,b,c,d,e,f,g,dp} with a at bit 7.
package seg7_pkg;

   localparam int MAX_DIGITS = 8;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Logical (active-high) {a..g} patterns for hex digits 0..F
   localparam logic [6:0] HEX_LUT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79,
      7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F,
      7'h4E, 7'h3D, 7'h4F, 7'h47
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble + dp to logical segment pattern.
// Blanking and pin polarity are handled by the caller.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = '0;
      seg_o[SEG_A:SEG_G] = HEX_LUT[nibble_i];
      seg_o[SEG_DP] = dp_i;
   end

endmodule

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: double-buffered, time-multiplexed N-digit 7-seg scanner.
// Optional `LEADING_ZERO_BLANK_EN darkens leading zero digits above digit 0.
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank,
   input  logic                  load,
   output logic [7:0]            seg,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_tick
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [PW-1:0] p_q, p_d;
   logic [IW-1:0] idx_q, idx_d;

   logic [4*N_DIGITS-1:0] sh_val_q, ds_val_q;
   logic [N_DIGITS-1:0]   sh_dp_q, ds_dp_q;
   logic [N_DIGITS-1:0]   sh_bl_q, ds_bl_q;

   logic [7:0]          seg_q, seg_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic                tick_q, tick_d;

   logic term, frame;
   logic [3:0] cur_nib;
   logic cur_dp, cur_bl, cur_lz;
   logic [N_DIGITS-1:0] lz;
   logic [7:0] dec_seg;

   assign term  = (p_q == P_LAST);
   assign frame = term && (idx_q == I_LAST);

   always_comb begin
      p_d   = term ? '0 : p_q + PW'(1);
      idx_d = idx_q;
      if (term) begin
         idx_d = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic zero_hi;

   // A digit is a leading zero when it and every digit above it are zero
   always_comb begin
      lz = '0;
      zero_hi = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_hi = zero_hi & (ds_val_q[4*k +: 4] == 4'h0);
         if (k != 0) lz[k] = zero_hi;
      end
   end
`else
   assign lz = '0;
`endif

   always_comb begin
      cur_nib = '0;
      cur_dp  = 1'b0;
      cur_bl  = 1'b0;
      cur_lz  = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_nib = ds_val_q[4*k +: 4];
            cur_dp  = ds_dp_q[k];
            cur_bl  = ds_bl_q[k];
            cur_lz  = lz[k];
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble_i (cur_nib),
      .dp_i     (cur_dp),
      .seg_o    (dec_seg)
   );

   // p = 0 is the anti-ghost dead cycle between slots
   always_comb begin
      seg_d  = '0;
      an_d   = '0;
      tick_d = frame;
      if (p_q != '0) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) an_d[k] = 1'b1;
         end
         if (cur_bl) begin
            seg_d = '0;
         end else if (cur_lz) begin
            seg_d[SEG_DP] = cur_dp;
         end else begin
            seg_d = dec_seg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q      <= '0;
         idx_q    <= '0;
         sh_val_q <= '0;
         sh_dp_q  <= '0;
         sh_bl_q  <= '0;
         ds_val_q <= '0;
         ds_dp_q  <= '0;
         ds_bl_q  <= '0;
         seg_q    <= {8{POL}};
         an_q     <= {N_DIGITS{POL}};
         tick_q   <= 1'b0;
      end else begin
         p_q   <= p_d;
         idx_q <= idx_d;
         if (load) begin
            sh_val_q <= value;
            sh_dp_q  <= dp_in;
            sh_bl_q  <= blank;
         end
         // Reload takes the pre-load shadow when load coincides
         if (frame) begin
            ds_val_q <= sh_val_q;
            ds_dp_q  <= sh_dp_q;
            ds_bl_q  <= sh_bl_q;
         end
         seg_q  <= seg_d ^ {8{POL}};
         an_q   <= an_d ^ {N_DIGITS{POL}};
         tick_q <= tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: randomized and directed checks of the scan driver
// against a cycle-count based reference model.
module tb_seg7_mux_driver;

   localparam int N  = 4;
   localparam int RD = 4;
   localparam int FR = N * RD;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  blank;
   logic        load;
   logic [7:0]  seg0, seg1;
   logic [3:0]  an0, an1;
   logic        tick0, tick1;

   int tests;
   int fails;

   seg7_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(0)) dut0 (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
      .blank(blank), .load(load),
      .seg(seg0), .an(an0), .frame_tick(tick0)
   );

   seg7_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
      .blank(blank), .load(load),
      .seg(seg1), .an(an1), .frame_tick(tick1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   // Reference model: position in the scan follows from the cycle count
   int          cnt;
   logic [15:0] m_sval, m_dval;
   logic [3:0]  m_sdp, m_ddp, m_sbl, m_dbl;
   logic [7:0]  e_seg;
   logic [3:0]  e_an;
   logic        e_tick;
   int          e_p, e_idx;

   function automatic logic [7:0] model_seg(int d);
      logic [3:0] nib;
      nib = m_dval[4*d +: 4];
      if (m_dbl[d]) return 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (m_dval >> (4*d)) == 16'h0) return {7'h0, m_ddp[d]};
`endif
      return {hex_tab[nib], m_ddp[d]};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         cnt = 0;
         m_sval = 0; m_sdp = 0; m_sbl = 0;
         m_dval = 0; m_ddp = 0; m_dbl = 0;
         e_seg = 0; e_an = 0; e_tick = 0; e_p = 0; e_idx = 0;
      end else begin
         e_p    = cnt % RD;
         e_idx  = (cnt / RD) % N;
         e_tick = (cnt % FR) == FR - 1;
         e_an   = (e_p == 0) ? 4'h0 : 4'(1 << e_idx);
         e_seg  = (e_p == 0) ? 8'h00 : model_seg(e_idx);
         if (e_tick) begin
            m_dval = m_sval; m_ddp = m_sdp; m_dbl = m_sbl;
         end
         if (load) begin
            m_sval = value; m_sdp = dp_in; m_sbl = blank;
         end
         cnt++;
      end
   end

   task automatic load_data(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] b);
      value = v; dp_in = d; blank = b; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = e_tick;
      end
   endtask

   task automatic test_reset();
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (10) begin
         @(negedge clk);
         tests++;
         if ({seg0, an0, tick0} !== 13'h0) begin
            fails++;
            $display("FAIL reset_al0: got %h/%b/%b want 00/0000/0",
                     seg0, an0, tick0);
         end
         tests++;
         if ({seg1, an1, tick1} !== {8'hFF, 4'hF, 1'b0}) begin
            fails++;
            $display("FAIL reset_al1: got %h/%b/%b want ff/1111/0",
                     seg1, an1, tick1);
         end
      end
      rst = 1'b0;
      for (int k = 0; k < FR; k++) begin
         @(negedge clk);
         tests++;
         if ({seg0, an0, tick0} !== {e_seg, e_an, e_tick}) begin
            fails++;
            $display("FAIL reset_frame k=%0d: got %h/%b/%b want %h/%b/%b",
                     k, seg0, an0, tick0, e_seg, e_an, e_tick);
         end
         if (k % RD != 0) begin
            tests++;
            if (seg0 !== 8'hFC) begin
               fails++;
               $display("FAIL reset_zero k=%0d: got %h want fc", k, seg0);
            end
         end
      end
   endtask

   task automatic test_load_1234();
      bit ok;
      logic [7:0] exp [4] = '{8'h66, 8'hF2, 8'hDA, 8'h60};
      load_data(16'h1234, 4'h0, 4'h0);
      wait_tick(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL load1234_tick: got none want tick");
      end
      for (int k = 0; k < FR; k++) begin
         @(negedge clk);
         tests++;
         if (k % RD == 0) begin
            if (an0 !== 4'b0000) begin
               fails++;
               $display("FAIL load1234_dead k=%0d: got %b want 0000", k, an0);
            end
         end else if ({an0, seg0} !== {4'(1 << (k / RD)), exp[k / RD]}) begin
            fails++;
            $display("FAIL load1234_slot k=%0d: got %b/%h want %b/%h",
                     k, an0, seg0, 4'(1 << (k / RD)), exp[k / RD]);
         end
         tests++;
         if ({seg1, an1, tick1} !== {~e_seg, ~e_an, e_tick}) begin
            fails++;
            $display("FAIL load1234_al1 k=%0d: got %h/%b want %h/%b",
                     k, seg1, an1, ~e_seg, ~e_an);
         end
      end
   endtask

   task automatic test_abcd_dp();
      bit ok;
      logic [7:0] exp [4] = '{8'h7A, 8'h9D, 8'h3E, 8'hEE};
      load_data(16'hABCD, 4'b0010, 4'h0);
      wait_tick(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL abcd_tick: got none want tick");
      end
      for (int k = 0; k < FR; k++) begin
         @(negedge clk);
         if (k % RD != 0) begin
            tests++;
            if (seg0 !== exp[k / RD]) begin
               fails++;
               $display("FAIL abcd_seg k=%0d: got %h want %h",
                        k, seg0, exp[k / RD]);
            end
         end
      end
   endtask

   task automatic test_coincident_load();
      logic [7:0] old_e [4] = '{8'h7A, 8'h9D, 8'h3E, 8'hEE};
      logic [7:0] new_e [4] = '{8'hFE, 8'hE0, 8'hBE, 8'hB6};
      for (int i = 0; i < 20 && (cnt % FR) != FR - 1; i++) @(negedge clk);
      tests++;
      if ((cnt % FR) != FR - 1) begin
         fails++;
         $display("FAIL coinc_align: got phase %0d want %0d", cnt % FR, FR-1);
      end
      load_data(16'h5678, 4'h0, 4'h0);
      tests++;
      if (tick0 !== 1'b1) begin
         fails++;
         $display("FAIL coinc_tick0: got %b want 1", tick0);
      end
      for (int k = 0; k < 2 * FR; k++) begin
         @(negedge clk);
         tests++;
         if (tick0 !== ((k % FR) == FR - 1)) begin
            fails++;
            $display("FAIL coinc_period k=%0d: got %b want %b",
                     k, tick0, (k % FR) == FR - 1);
         end
         if (k % RD != 0) begin
            tests++;
            if (seg0 !== (k < FR ? old_e[(k % FR) / RD]
                                 : new_e[(k % FR) / RD])) begin
               fails++;
               $display("FAIL coinc_seg k=%0d: got %h want %h", k, seg0,
                        k < FR ? old_e[(k % FR) / RD] : new_e[(k % FR) / RD]);
            end
         end
      end
   endtask

   task automatic test_blank_al();
      bit ok;
      load_data(16'h4321, 4'b0100, 4'b0100);
      wait_tick(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL blank_tick: got none want tick");
      end
      for (int k = 0; k < FR; k++) begin
         @(negedge clk);
         if (k / RD == 2 && k % RD != 0) begin
            tests++;
            if ({an1, seg1, seg0} !== {4'b1011, 8'hFF, 8'h00}) begin
               fails++;
               $display("FAIL blank_d2 k=%0d: got %b/%h/%h want 1011/ff/00",
                        k, an1, seg1, seg0);
            end
         end
         tests++;
         if ({seg0, an0, tick0} !== {e_seg, e_an, e_tick}) begin
            fails++;
            $display("FAIL blank_model k=%0d: got %h/%b want %h/%b",
                     k, seg0, an0, e_seg, e_an);
         end
      end
   endtask

   task automatic test_lzb();
      bit ok;
`ifdef LEADING_ZERO_BLANK_EN
      logic [7:0] exp [4] = '{8'hFC, 8'hB6, 8'h00, 8'h00};
`else
      logic [7:0] exp [4] = '{8'hFC, 8'hB6, 8'hFC, 8'hFC};
`endif
      load_data(16'h0050, 4'h0, 4'h0);
      wait_tick(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL lzb_tick: got none want tick");
      end
      for (int k = 0; k < FR; k++) begin
         @(negedge clk);
         if (k % RD != 0) begin
            tests++;
            if (seg0 !== exp[k / RD]) begin
               fails++;
               $display("FAIL lzb_seg k=%0d: got %h want %h",
                        k, seg0, exp[k / RD]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (!rst) begin
            tests++;
            if ({seg0, an0, tick0} !== {e_seg, e_an, e_tick}) begin
               fails++;
               $display("FAIL rand_al0 i=%0d: got %h/%b/%b want %h/%b/%b",
                        i, seg0, an0, tick0, e_seg, e_an, e_tick);
            end
            tests++;
            if ({seg1, an1, tick1} !== {~e_seg, ~e_an, e_tick}) begin
               fails++;
               $display("FAIL rand_al1 i=%0d: got %h/%b/%b want %h/%b/%b",
                        i, seg1, an1, tick1, ~e_seg, ~e_an, e_tick);
            end
         end
         for (int d = 0; d < 4; d++) begin
            v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0
                          : 4'($urandom_range(0, 15));
         end
         value = v;
         dp_in = 4'($urandom_range(0, 15));
         blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         load  = ($urandom_range(0, 9) == 0);
         rst   = (i >= 300 && i < 303);
      end
      load = 1'b0;
      rst  = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      value = '0;
      dp_in = '0;
      blank = '0;
      load  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_load_1234();
      test_abcd_dp();
      test_coincident_load();
      test_blank_al();
      test_lzb();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
